// File: rtl/siphash_sched_pkg.sv
// Shared types and constants for the SipHash nonce-search scheduler.
package siphash_sched_pkg;

    localparam int NONCE_W = 64;
    localparam int KEY_W   = 256;
    localparam int HASH_W  = 64;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } sched_state_t;

    typedef struct packed {
        logic [NONCE_W-1:0] nonce;
        logic [HASH_W-1:0]  hash;
    } hit_rec_t;

    localparam int HIT_W = $bits(hit_rec_t);

endpackage

// File: rtl/siphash_nonce_sched_if.sv
// Core-side hash bus plus the ready/valid hit stream of the nonce scheduler.
interface siphash_nonce_sched_if;

    logic                                   hash_we;
    logic [siphash_sched_pkg::KEY_W-1:0]    hash_key;
    logic [siphash_sched_pkg::NONCE_W-1:0]  hash_nonce;
    logic [siphash_sched_pkg::HASH_W-1:0]   hash_result;

    logic                                   hit_valid;
    logic                                   hit_ready;
    logic [siphash_sched_pkg::NONCE_W-1:0]  hit_nonce;
    logic [siphash_sched_pkg::HASH_W-1:0]   hit_hash;

    modport master (
        output hash_we, hash_key, hash_nonce,
        input  hash_result,
        output hit_valid, hit_nonce, hit_hash,
        input  hit_ready
    );

    modport slave (
        input  hash_we, hash_key, hash_nonce,
        output hash_result,
        input  hit_valid, hit_nonce, hit_hash,
        output hit_ready
    );

endinterface

// File: rtl/siphash_hit_fifo.sv
// First-word fall-through synchronous FIFO that exports its occupancy.
module siphash_hit_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 128,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             full;
    logic             do_pop;
    logic             do_push;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO may still accept a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= push_data;
    end

    assign head_data = mem[rd_ptr_reg];
    assign count     = count_reg;

endmodule

// File: rtl/siphash_nonce_sched.sv
// Credit-gated nonce issue, in-order retire tracking and target compare for a pipelined SipHash core.
// Optional statistics outputs are built when SIPHASH_SCHED_STATS_EN is defined.
module siphash_nonce_sched
    import siphash_sched_pkg::*;
#(
    parameter int PIPE_LAT   = 10,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 32
) (
    input  logic                 CLOCK,
    input  logic                 reset,
    input  logic [KEY_W-1:0]     cfg_key,
    input  logic [NONCE_W-1:0]   cfg_start_nonce,
    input  logic [CNT_W-1:0]     cfg_count,
    input  logic [HASH_W-1:0]    cfg_target,
    input  logic                 start,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    siphash_nonce_sched_if.master bus
`ifdef SIPHASH_SCHED_STATS_EN
    ,
    output logic [CNT_W-1:0]     stat_hashes,
    output logic [CNT_W-1:0]     stat_hits
`endif
);

    localparam int FW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [FW:0] DEPTH_V = (FW+1)'(FIFO_DEPTH);

    sched_state_t       state_reg, state_next;
    logic [KEY_W-1:0]   key_reg;
    logic [HASH_W-1:0]  target_reg;
    logic [NONCE_W-1:0] issue_nonce_reg;
    logic [NONCE_W-1:0] retire_nonce_reg;
    logic [CNT_W-1:0]   remaining_reg;
    logic [FW-1:0]      inflight_reg, inflight_next;
    logic [PIPE_LAT-1:0] vld_sr_reg, vld_sr_next;
    logic [FW-1:0]      fifo_count;
    logic [FW:0]        credit_sum;
    logic               fifo_empty;
    logic               credit_ok;
    logic               start_acc;
    logic               issue;
    logic               retire;
    logic               is_hit;
    hit_rec_t           push_rec;
    hit_rec_t           head_rec;

    assign start_acc  = (state_reg == IDLE) && start;
    // Credit uses registered counts only, so a result always has a FIFO slot on retire.
    assign credit_sum = {1'b0, inflight_reg} + {1'b0, fifo_count};
    assign credit_ok  = credit_sum < DEPTH_V;
    assign issue      = (state_reg == RUN) && (remaining_reg != '0) && credit_ok;
    assign retire     = vld_sr_reg[PIPE_LAT-1];
    assign is_hit     = retire && (bus.hash_result < target_reg);

    always_comb begin
        inflight_next = inflight_reg;
        case ({issue, retire})
            2'b10:   inflight_next = inflight_reg + 1'b1;
            2'b01:   inflight_next = inflight_reg - 1'b1;
            default: inflight_next = inflight_reg;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < PIPE_LAT; gi++) begin : g_vld
            if (gi == 0) begin : g_head
                assign vld_sr_next[gi] = issue;
            end else begin : g_tail
                assign vld_sr_next[gi] = vld_sr_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge CLOCK) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (start) state_next = RUN;
            RUN:   if (abort || remaining_reg == '0 ||
                       (issue && remaining_reg == CNT_W'(1))) state_next = DRAIN;
            DRAIN: if (inflight_next == '0) state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy           = (state_reg == RUN) || (state_reg == DRAIN);
        done           = (state_reg == DONE);
        bus.hash_we    = issue;
        bus.hash_nonce = issue_nonce_reg;
        bus.hash_key   = key_reg;
    end

    always_ff @(posedge CLOCK) begin
        if (reset) begin
            key_reg          <= '0;
            target_reg       <= '0;
            issue_nonce_reg  <= '0;
            retire_nonce_reg <= '0;
            remaining_reg    <= '0;
            inflight_reg     <= '0;
            vld_sr_reg       <= '0;
        end else begin
            vld_sr_reg   <= vld_sr_next;
            inflight_reg <= inflight_next;
            if (start_acc) begin
                key_reg          <= cfg_key;
                target_reg       <= cfg_target;
                issue_nonce_reg  <= cfg_start_nonce;
                retire_nonce_reg <= cfg_start_nonce;
                remaining_reg    <= cfg_count;
            end else begin
                if (issue) begin
                    issue_nonce_reg <= issue_nonce_reg + 1'b1;
                    remaining_reg   <= remaining_reg - 1'b1;
                end
                // Issue is strictly in order, so the retiring nonce is just a second counter.
                if (retire) retire_nonce_reg <= retire_nonce_reg + 1'b1;
            end
        end
    end

    assign push_rec = '{nonce: retire_nonce_reg, hash: bus.hash_result};

    siphash_hit_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (HIT_W)
    ) u_fifo (
        .clk       (CLOCK),
        .srst      (reset),
        .push      (is_hit),
        .push_data (push_rec),
        .pop       (bus.hit_ready),
        .head_data (head_rec),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign bus.hit_valid = !fifo_empty;
    assign bus.hit_nonce = head_rec.nonce;
    assign bus.hit_hash  = head_rec.hash;

`ifdef SIPHASH_SCHED_STATS_EN
    logic [CNT_W-1:0] stat_hashes_reg;
    logic [CNT_W-1:0] stat_hits_reg;

    always_ff @(posedge CLOCK) begin
        if (reset || start_acc) begin
            stat_hashes_reg <= '0;
            stat_hits_reg   <= '0;
        end else begin
            if (retire && stat_hashes_reg != '1) stat_hashes_reg <= stat_hashes_reg + 1'b1;
            if (is_hit && stat_hits_reg != '1)   stat_hits_reg   <= stat_hits_reg + 1'b1;
        end
    end

    assign stat_hashes = stat_hashes_reg;
    assign stat_hits   = stat_hits_reg;
`endif

endmodule

// File: tb/tb_siphash_nonce_sched.sv
// Scoreboard bench for siphash_nonce_sched with a fixed-latency XOR core model.
module tb_siphash_nonce_sched;
    import siphash_sched_pkg::*;

    localparam int PIPE_LAT   = 10;
    localparam int FIFO_DEPTH = 16;
    localparam int CNT_W      = 32;
    localparam logic [63:0] HMASK = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] ALL1  = 64'hFFFF_FFFF_FFFF_FFFF;

    logic               CLOCK = 1'b0;
    logic               reset;
    logic [KEY_W-1:0]   cfg_key;
    logic [63:0]        cfg_start_nonce;
    logic [CNT_W-1:0]   cfg_count;
    logic [63:0]        cfg_target;
    logic               start;
    logic               abort;
    logic               busy;
    logic               done;
`ifdef SIPHASH_SCHED_STATS_EN
    logic [CNT_W-1:0]   stat_hashes;
    logic [CNT_W-1:0]   stat_hits;
`endif

    siphash_nonce_sched_if bus_if();

    siphash_nonce_sched #(
        .PIPE_LAT   (PIPE_LAT),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .CLOCK           (CLOCK),
        .reset           (reset),
        .cfg_key         (cfg_key),
        .cfg_start_nonce (cfg_start_nonce),
        .cfg_count       (cfg_count),
        .cfg_target      (cfg_target),
        .start           (start),
        .abort           (abort),
        .busy            (busy),
        .done            (done),
        .bus             (bus_if)
`ifdef SIPHASH_SCHED_STATS_EN
        ,
        .stat_hashes     (stat_hashes),
        .stat_hits       (stat_hits)
`endif
    );

    always #5 CLOCK = ~CLOCK;

    function automatic logic [63:0] hfun(input logic [63:0] n);
        return n ^ HMASK;
    endfunction

    // Core model: fixed latency, result depends only on the issued nonce.
    logic [PIPE_LAT-1:0] p_vld;
    logic [63:0]         p_nonce [PIPE_LAT];

    always @(posedge CLOCK) begin
        if (reset) p_vld <= '0;
        else       p_vld <= {p_vld[PIPE_LAT-2:0], bus_if.hash_we};
        p_nonce[0] <= bus_if.hash_nonce;
        for (int i = 1; i < PIPE_LAT; i++) p_nonce[i] <= p_nonce[i-1];
    end

    assign bus_if.hash_result = hfun(p_nonce[PIPE_LAT-1]);

    hit_rec_t    exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          issued, popped, done_cnt, done_cyc, last_retire_cyc, max_out;
    logic [63:0] exp_issue;
    logic [63:0] last_nonce;
    logic [KEY_W-1:0] key_v;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(posedge CLOCK) cyc <= cyc + 1;

    // Monitor: issue order, retire timing, done pulses, hit scoreboard.
    always @(negedge CLOCK) begin
        hit_rec_t e;
        if (!reset) begin
            if (bus_if.hash_we) begin
                check("issue_nonce", bus_if.hash_nonce, exp_issue);
                exp_issue  = exp_issue + 64'd1;
                last_nonce = bus_if.hash_nonce;
                issued++;
            end
            if (p_vld[PIPE_LAT-1]) last_retire_cyc = cyc;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (bus_if.hit_valid && bus_if.hit_ready) begin
                popped++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL hit_unexpected: got nonce %h hash %h, expected no hit",
                             bus_if.hit_nonce, bus_if.hit_hash);
                end else begin
                    e = exp_q.pop_front();
                    check("hit_nonce", bus_if.hit_nonce, e.nonce);
                    check("hit_hash", bus_if.hit_hash, e.hash);
                end
            end
            if (issued - popped > max_out) max_out = issued - popped;
        end
    end

    task automatic run_start(input logic [63:0] sn, input logic [CNT_W-1:0] cnt,
                             input logic [63:0] tgt, input int n_exp);
        logic [63:0] n;
        issued = 0; popped = 0; done_cnt = 0; max_out = 0;
        @(posedge CLOCK); #1;
        key_v           = {sn, ~sn, sn ^ HMASK, HMASK};
        cfg_key         = key_v;
        cfg_start_nonce = sn;
        cfg_count       = cnt;
        cfg_target      = tgt;
        start           = 1'b1;
        exp_issue       = sn;
        for (int i = 0; i < n_exp; i++) begin
            n = sn + 64'(i);
            if (hfun(n) < tgt) exp_q.push_back(hit_rec_t'{nonce: n, hash: hfun(n)});
        end
        @(posedge CLOCK); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int k = 0;
        while (done_cnt == 0 && k < budget) begin
            @(posedge CLOCK); #1;
            k++;
        end
        check(name, 64'(done_cnt != 0), 64'd1);
    endtask

    task automatic wait_empty(input string name, input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(posedge CLOCK); #1;
            k++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        cfg_key = '0; cfg_start_nonce = '0; cfg_count = '0; cfg_target = '0;
        bus_if.hit_ready = 1'b0;
        exp_issue = '0; last_nonce = '0; key_v = '0;
        issued = 0; popped = 0; done_cnt = 0; done_cyc = 0; last_retire_cyc = 0; max_out = 0;
        repeat (3) @(posedge CLOCK);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hash_we", 64'(bus_if.hash_we), 64'd0);
        check("rst_hit_valid", 64'(bus_if.hit_valid), 64'd0);
        check("rst_hash_key", 64'(bus_if.hash_key != '0), 64'd0);
        check("rst_hash_nonce", bus_if.hash_nonce, 64'd0);
        reset = 1'b0;

        // 1: all results hit, consumer always ready
        bus_if.hit_ready = 1'b1;
        run_start(64'd0, 20, ALL1, 20);
        check("t1_busy", 64'(busy), 64'd1);
        check("t1_key", 64'(bus_if.hash_key == key_v), 64'd1);
        wait_done("t1_done", 100);
        wait_empty("t1_drain", 50);
        repeat (3) @(posedge CLOCK);
        #1;
        check("t1_issued", 64'(issued), 64'd20);
        check("t1_popped", 64'(popped), 64'd20);
        check("t1_done_lat", 64'(done_cyc - last_retire_cyc), 64'd1);
        check("t1_done_pulses", 64'(done_cnt), 64'd1);
        check("t1_idle", 64'(busy), 64'd0);
`ifdef SIPHASH_SCHED_STATS_EN
        check("t1_stat_hashes", 64'(stat_hashes), 64'd20);
        check("t1_stat_hits", 64'(stat_hits), 64'd20);
`endif

        // 2: target 0, nothing can hit
        run_start(64'd0, 100, 64'd0, 100);
        wait_done("t2_done", 300);
        repeat (3) @(posedge CLOCK);
        #1;
        check("t2_issued", 64'(issued), 64'd100);
        check("t2_popped", 64'(popped), 64'd0);
        check("t2_done_pulses", 64'(done_cnt), 64'd1);

        // 3: consumer stalled, issue must stop at FIFO_DEPTH outstanding
        bus_if.hit_ready = 1'b0;
        run_start(64'h1000, 50, ALL1, 50);
        repeat (60) @(posedge CLOCK);
        #1;
        check("t3_stall_issued", 64'(issued), 64'd16);
        check("t3_hit_valid", 64'(bus_if.hit_valid), 64'd1);
        bus_if.hit_ready = 1'b1;
        wait_done("t3_done", 500);
        wait_empty("t3_drain", 100);
        check("t3_issued", 64'(issued), 64'd50);
        check("t3_popped", 64'(popped), 64'd50);
        check("t3_max_outstanding", 64'(max_out), 64'd16);

        // 4: nonce wrap
        run_start(64'hFFFF_FFFF_FFFF_FFFE, 4, ALL1, 4);
        wait_done("t4_done", 100);
        wait_empty("t4_drain", 50);
        check("t4_issued", 64'(issued), 64'd4);
        check("t4_last_nonce", last_nonce, 64'd1);
        check("t4_popped", 64'(popped), 64'd4);

        // 5: abort in the fifth RUN cycle, start while busy ignored
        run_start(64'h2000, 1000, ALL1, 5);
        repeat (4) @(posedge CLOCK);
        #1;
        abort = 1'b1;
        @(posedge CLOCK); #1;
        abort = 1'b0;
        check("t5_busy_drain", 64'(busy), 64'd1);
        cfg_start_nonce = 64'hDEAD;
        cfg_count = 7;
        start = 1'b1;
        @(posedge CLOCK); #1;
        start = 1'b0;
        wait_done("t5_done", 100);
        wait_empty("t5_drain", 50);
        repeat (3) @(posedge CLOCK);
        #1;
        check("t5_issued", 64'(issued), 64'd5);
        check("t5_popped", 64'(popped), 64'd5);
        check("t5_done_pulses", 64'(done_cnt), 64'd1);

        // 7: partial target, nonces 8..15 hit
        run_start(64'd0, 16, 64'h0123_4567_89AB_CDE8, 16);
        wait_done("t7_done", 100);
        wait_empty("t7_drain", 50);
        check("t7_popped", 64'(popped), 64'd8);

        // 6: zero count, then reset in the middle of a run
        run_start(64'd0, 0, ALL1, 0);
        wait_done("t6_done", 3);
        check("t6_issued", 64'(issued), 64'd0);
        bus_if.hit_ready = 1'b0;
        run_start(64'd0, 1000, ALL1, 0);
        repeat (30) @(posedge CLOCK);
        #1;
        check("t6_pre_hit_valid", 64'(bus_if.hit_valid), 64'd1);
        reset = 1'b1;
        @(posedge CLOCK); #1;
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_hit_valid", 64'(bus_if.hit_valid), 64'd0);
        reset = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge CLOCK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
